// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_bridge
//  Description : Turns a valid/ready command stream into single Wishbone
//                pipelined bus cycles and returns a valid/ready response
//                carrying read data, an error flag and a timeout flag.
//                Only one transaction is ever outstanding.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_n_i        : clock (rising edge), async active-low reset
//    req_*                 : command channel (we, byte address, data, sel)
//    rsp_*                 : response channel (data, err, timeout)
//    wb_cyc_o .. wb_dat_o  : Wishbone pipelined master outputs
//    wb_ack_i .. wb_dat_i  : Wishbone master inputs
// ============================================================================
module wb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // command channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_data_i,
    input  logic [3:0]            req_sel_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    // Wishbone master
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STB  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    // One extra bit so the compare against TIMEOUT never wraps.
    localparam logic [16:0] C_TIMEOUT = 17'(TIMEOUT);

    state_t      r_state;
    logic [15:0] r_cnt;

    logic        w_term;
    logic [16:0] w_cnt_inc;

    assign w_term    = wb_ack_i | wb_err_i | wb_rty_i;
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_sel_o      <= '0;
            wb_dat_o      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // req_ready_o is low for the first cycle after reset
                    // release, so acceptance also requires it to be high.
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        wb_we_o     <= req_we_i;
                        wb_adr_o    <= req_addr_i;
                        wb_dat_o    <= req_data_i;
                        wb_sel_o    <= req_sel_i;
                        r_cnt       <= '0;
                        r_state     <= ST_STB;
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end

                ST_STB, ST_WAIT: begin
                    r_cnt <= w_cnt_inc[15:0];
                    if (w_term || (w_cnt_inc == C_TIMEOUT)) begin
                        // Close the bus cycle; bus outputs return to zero
                        // so they read as idle while the response waits.
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_we_o     <= 1'b0;
                        wb_adr_o    <= '0;
                        wb_sel_o    <= '0;
                        wb_dat_o    <= '0;
                        rsp_valid_o <= 1'b1;
                        r_state     <= ST_RSP;
                        if (w_term) begin
                            // A slave termination beats a coincident timeout;
                            // err/rty beat ack, and only a read ack carries data.
                            rsp_err_o     <= wb_err_i | wb_rty_i;
                            rsp_timeout_o <= 1'b0;
                            rsp_data_o    <= (!wb_err_i && !wb_rty_i && !wb_we_o)
                                             ? wb_dat_i : 32'd0;
                        end else begin
                            rsp_err_o     <= 1'b1;
                            rsp_timeout_o <= 1'b1;
                            rsp_data_o    <= 32'd0;
                        end
                    end else if ((r_state == ST_STB) && !wb_stall_i) begin
                        // Strobe taken by the slave; keep cyc and wait.
                        wb_stb_o <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o   <= 1'b0;
                        rsp_data_o    <= '0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        req_ready_o   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_master_bridge
//  Description : Self-checking bench for wb_master_bridge. A cycle-level
//                behavioural model of the bridge is compared against every
//                DUT output on each falling clock edge; directed transactions
//                add literal checks of latency, counts and response fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_bridge;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    wb_master_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a transaction is "open" on the bus from the
    // cycle after acceptance until it ends, then a response is pending
    // until consumed. Everything else derives from these few facts.
    // ------------------------------------------------------------------
    bit          m_rdy_ok = 1'b0;
    bit          m_open = 1'b0;
    bit          m_stb = 1'b0;
    bit          m_rv = 1'b0;
    bit          m_err = 1'b0;
    bit          m_to = 1'b0;
    int          m_age = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rdata = '0;
    logic [3:0]  m_sel = '0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_rdy_ok = 1'b0; m_open = 1'b0; m_stb = 1'b0; m_rv = 1'b0;
            m_err = 1'b0; m_to = 1'b0; m_age = 0; m_rdata = '0;
        end else if (m_rv) begin
            if (rsp_ready_i) m_rv = 1'b0;
        end else if (m_open) begin
            m_age++;
            if (wb_err_i || wb_rty_i) begin
                m_open = 1'b0; m_stb = 1'b0; m_rv = 1'b1;
                m_err = 1'b1; m_to = 1'b0; m_rdata = '0;
            end else if (wb_ack_i) begin
                m_open = 1'b0; m_stb = 1'b0; m_rv = 1'b1;
                m_err = 1'b0; m_to = 1'b0; m_rdata = m_we ? 32'd0 : wb_dat_i;
            end else if (m_age == TO) begin
                m_open = 1'b0; m_stb = 1'b0; m_rv = 1'b1;
                m_err = 1'b1; m_to = 1'b1; m_rdata = '0;
            end else if (!wb_stall_i) begin
                m_stb = 1'b0;
            end
        end else begin
            if (req_valid_i && m_rdy_ok) begin
                m_open = 1'b1; m_stb = 1'b1; m_age = 0;
                m_we = req_we_i; m_adr = req_addr_i; m_dat = req_data_i; m_sel = req_sel_i;
            end
            m_rdy_ok = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("req_ready", req_ready_o, m_rdy_ok && !m_open && !m_rv);
            chk("wb_cyc", wb_cyc_o, m_open);
            chk("wb_stb", wb_stb_o, m_stb);
            chk("wb_we", wb_we_o, m_open ? m_we : 1'b0);
            chk("wb_adr", wb_adr_o, m_open ? m_adr : 32'd0);
            chk("wb_dat", wb_dat_o, m_open ? m_dat : 32'd0);
            chk("wb_sel", wb_sel_o, m_open ? m_sel : 4'd0);
            chk("rsp_valid", rsp_valid_o, m_rv);
            chk("rsp_data", rsp_data_o, m_rv ? m_rdata : 32'd0);
            chk("rsp_err", rsp_err_o, m_rv ? m_err : 1'b0);
            chk("rsp_timeout", rsp_timeout_o, m_rv ? m_to : 1'b0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        int guard;
        req_we_i = we; req_addr_i = adr; req_data_i = dat; req_sel_i = sel;
        req_valid_i = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        chk("accept_ready", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_sel_i = '0;
    endtask

    // kind: 0 ack, 1 err, 2 rty, 3 err+ack. term_cyc 0 = slave never answers.
    task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int stall_cyc, input int term_cyc,
                          input int kind, input logic [31:0] rdata, input int hold,
                          output int stb_cnt, output int cyc_cnt, output int lat,
                          output logic [31:0] r_data, output logic r_err, output logic r_to);
        stb_cnt = 0; cyc_cnt = 0; lat = 0; r_data = '0; r_err = 1'b0; r_to = 1'b0;
        accept(we, adr, dat, sel);
        wb_dat_i = rdata;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid_o) begin
                lat = c;
                break;
            end
            stb_cnt += int'(wb_stb_o);
            cyc_cnt += int'(wb_cyc_o);
            wb_stall_i = (c <= stall_cyc);
            wb_ack_i   = (c == term_cyc) && (kind == 0 || kind == 3);
            wb_err_i   = (c == term_cyc) && (kind == 1 || kind == 3);
            wb_rty_i   = (c == term_cyc) && (kind == 2);
            tick();
        end
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        chk("rsp_seen", rsp_valid_o, 1'b1);
        r_data = rsp_data_o; r_err = rsp_err_o; r_to = rsp_timeout_o;
        for (int h = 0; h < hold; h++) begin
            req_valid_i = 1'b1; req_addr_i = 32'h100; req_we_i = 1'b1;
            tick();
            chk("hold_req_ready", req_ready_o, 1'b0);
            chk("hold_rsp_valid", rsp_valid_o, 1'b1);
        end
        req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        wb_dat_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, cc, lat;
        logic [31:0] d;
        logic e, t;

        #2 rst_n_i = 1'b0;
        #1 chk_en = 1'b1;
        chk("reset_req_ready", req_ready_o, 1'b0);
        chk("reset_cyc", wb_cyc_o, 1'b0);
        chk("reset_rsp_valid", rsp_valid_o, 1'b0);
        tick(); tick();
        rst_n_i = 1'b1;
        chk("release_ready_low", req_ready_o, 1'b0);
        tick();
        chk("ready_after_first_edge", req_ready_o, 1'b1);

        // Terminations while idle are ignored
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
        tick(); tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        chk("idle_term_no_rsp", rsp_valid_o, 1'b0);

        // Write with one stall cycle, ack in the WAIT cycle
        do_txn(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 1, 3, 0, 32'h0, 0, sc, cc, lat, d, e, t);
        chk("wr_stb_cycles", sc, 2);
        chk("wr_cyc_cycles", cc, 3);
        chk("wr_latency", lat, 4);
        chk("wr_err", e, 1'b0);
        chk("wr_data", d, 32'h0);

        // Read, ack in first STB cycle: minimum latency
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1, 0, 32'hDEADBEEF, 0, sc, cc, lat, d, e, t);
        chk("rd_latency", lat, 2);
        chk("rd_data", d, 32'hDEADBEEF);
        chk("rd_err", e, 1'b0);

        // Silent slave: timeout after TO open cycles
        do_txn(1'b0, 32'h40, 32'h0, 4'h3, 0, 0, 0, 32'h11111111, 0, sc, cc, lat, d, e, t);
        chk("to_cyc_cycles", cc, TO);
        chk("to_err", e, 1'b1);
        chk("to_flag", t, 1'b1);
        chk("to_data", d, 32'h0);

        // err together with ack: err wins, data dropped
        do_txn(1'b0, 32'h8, 32'h0, 4'hF, 0, 2, 3, 32'h5A5A5A5A, 0, sc, cc, lat, d, e, t);
        chk("errack_err", e, 1'b1);
        chk("errack_data", d, 32'h0);
        chk("errack_to", t, 1'b0);

        // Retry on a write
        do_txn(1'b1, 32'hC, 32'h01020304, 4'h1, 2, 2, 2, 32'h0, 0, sc, cc, lat, d, e, t);
        chk("rty_err", e, 1'b1);
        chk("rty_stb_cycles", sc, 2);

        // Ack on the very cycle the counter hits TIMEOUT
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, TO, 0, 32'h12345678, 0, sc, cc, lat, d, e, t);
        chk("edge_to_flag", t, 1'b0);
        chk("edge_err", e, 1'b0);
        chk("edge_data", d, 32'h12345678);

        // Stall and ack in the same cycle still terminates
        do_txn(1'b0, 32'h24, 32'h0, 4'hF, 1, 1, 0, 32'hA5A5A5A5, 0, sc, cc, lat, d, e, t);
        chk("stallack_latency", lat, 2);
        chk("stallack_stb", sc, 1);

        // Back-pressured response with a competing request
        do_txn(1'b0, 32'h28, 32'h0, 4'hF, 0, 2, 0, 32'h0BADF00D, 5, sc, cc, lat, d, e, t);
        chk("hold_data", d, 32'h0BADF00D);
        chk("hold_idle_ready", req_ready_o, 1'b1);

        // Reset pulse while in WAIT
        accept(1'b0, 32'h30, 32'h0, 4'hF);
        tick();
        chk("pre_rst_cyc", wb_cyc_o, 1'b1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("rst_cyc_async", wb_cyc_o, 1'b0);
        chk("rst_ready_low", req_ready_o, 1'b0);
        #1 rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_rsp_after_rst", rsp_valid_o, 1'b0);
        end

        // Normal read after the abort
        do_txn(1'b0, 32'h34, 32'h0, 4'hF, 0, 1, 0, 32'hCAFEF00D, 0, sc, cc, lat, d, e, t);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_data", d, 32'hCAFEF00D);

        tick(); tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles a bus cycle may stay open before abort (range 1..65535).
REQ-003 SHALL have port clk_i, in, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n_i, in, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i, in, 1, command request.
REQ-006 SHALL have port req_ready_o, out, 1, command accepted when req_valid_i & req_ready_o.
REQ-007 SHALL have port req_we_i, in, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i, in, ADDR_WIDTH, byte address.
REQ-009 SHALL have port req_data_i, in, 32, write data.
REQ-010 SHALL have port req_sel_i, in, 4, byte enables.
REQ-011 SHALL have port rsp_valid_o, out, 1, response available.
REQ-012 SHALL have port rsp_ready_i, in, 1, response consumed when rsp_valid_o & rsp_ready_i.
REQ-013 SHALL have port rsp_data_o, out, 32, read data (0 for writes).
REQ-014 SHALL have port rsp_err_o, out, 1, bus error, retry or timeout.
REQ-015 SHALL have port rsp_timeout_o, out, 1, abort caused by timeout.
REQ-016 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o (out, 1), wb_adr_o (out, ADDR_WIDTH), wb_sel_o (out, 4), wb_dat_o (out, 32), Wishbone pipelined master outputs.
REQ-017 SHALL have ports wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i (in, 1), wb_dat_i (in, 32), Wishbone master inputs.

Function
REQ-018 SHALL implement FSM states IDLE, STB, WAIT, RSP; every output SHALL be driven from registers.
REQ-019 IDLE: req_ready_o=1, all other outputs 0. An accepted command SHALL latch we/addr/data/sel and enter STB.
REQ-020 STB: wb_cyc_o=1, wb_stb_o=1, wb_adr_o/wb_we_o/wb_sel_o/wb_dat_o SHALL hold the latched command; cycle 1 after acceptance is the first STB cycle.
REQ-021 STB: with wb_stall_i=1 and no termination, SHALL remain in STB with all bus outputs held stable.
REQ-022 STB: with wb_stall_i=0 and no termination, SHALL enter WAIT (wb_stb_o=0, wb_cyc_o=1).
REQ-023 Termination: wb_ack_i, wb_err_i or wb_rty_i sampled high in STB or WAIT. SHALL drop wb_cyc_o/wb_stb_o next cycle and enter RSP. Applies even with wb_stall_i=1 in the same cycle.
REQ-024 Priority: err over rty over ack. rsp_err_o=1 for err or rty. rsp_data_o=wb_dat_i captured only on ack of a read, else 0.
REQ-025 Timeout counter: cleared on acceptance, incremented each STB/WAIT cycle. When it reaches TIMEOUT without termination, SHALL enter RSP with rsp_err_o=1, rsp_timeout_o=1, rsp_data_o=0, and drop wb_cyc_o.
REQ-026 Termination in the same cycle the counter reaches TIMEOUT SHALL take precedence; rsp_timeout_o=0.
REQ-027 RSP: rsp_valid_o=1, response fields stable until rsp_ready_i=1. Then IDLE next cycle.
REQ-028 Exactly one outstanding transaction; req_ready_o=0 outside IDLE.
REQ-029 Termination inputs sampled in IDLE or RSP SHALL be ignored.
REQ-030 Minimum latency, acceptance to rsp_valid_o, SHALL be 2 cycles (slave ack in first STB cycle).

Reset
REQ-031 On rst_n_i low, SHALL immediately (asynchronously) force IDLE, counter 0, and all outputs 0 except req_ready_o.
REQ-032 req_ready_o SHALL be 0 while rst_n_i is low and 1 from the first clock edge after release.
REQ-033 Reset in mid-transaction SHALL drop wb_cyc_o asynchronously; no response SHALL be issued for the aborted command.

Verification
REQ-034 Write addr 0x0, data 0xDEADBEEF, sel 0xF; slave stalls, then acks 2 cycles after first stb -> wb_stb_o high 2 cycles with stable outputs; rsp_valid_o=1, rsp_err_o=0 one cycle after ack.
REQ-035 Read back addr 0x0, slave returns 0xDEADBEEF with ack -> rsp_data_o=0xDEADBEEF, rsp_err_o=0.
REQ-036 TIMEOUT=4, slave never responds -> wb_cyc_o drops after 4 STB/WAIT cycles; rsp_err_o=1, rsp_timeout_o=1, rsp_data_o=0.
REQ-037 Slave asserts wb_err_i and wb_ack_i together on a read of 0x5A5A5A5A -> rsp_err_o=1, rsp_data_o=0.
REQ-038 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and fields stable, req_ready_o=0; new req_valid_i not accepted until RSP completes.
REQ-039 rst_n_i pulsed low during WAIT -> wb_cyc_o=0 immediately; no rsp_valid_o; next command completes normally.
